// File: rtl/mem_wb_pkg.sv
// rtl/mem_wb_pkg.sv - shared types and defaults for the MEM->WB skid register
package mem_wb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DST_W_DEF  = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } mem_wb_state_t;

    // Entry layout at default widths. The two control bits sit at the MSB end,
    // so a flat slot vector keeps them at [W-1:W-2] at any width.
    typedef struct packed {
        logic                  wb_en;
        logic                  mem_rd_en;
        logic [DATA_W_DEF-1:0] alu_result;
        logic [DATA_W_DEF-1:0] mem_data;
        logic [DST_W_DEF-1:0]  dst;
    } mem_wb_entry_t;

    function automatic int entry_w(input int data_w, input int dst_w);
        return 2 + 2 * data_w + dst_w;
    endfunction

endpackage

// File: rtl/mem_wb_entry.sv
// rtl/mem_wb_entry.sv - one pipeline slot register with load and control-bit clear
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (slot resets to 0)
//   i_load       capture i_d on the rising edge
//   i_clr_ctrl   clear the two control bits [W-1:W-2]; payload is kept
//   i_d          next slot contents
//   o_q          current slot contents
module mem_wb_entry #(
    parameter int W = 70
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_clr_ctrl,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // A clear wins over a load: a flushed slot must never carry live control bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr_ctrl) begin
            r_q[W-1 -: 2] <= 2'b00;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mem_wb_skid_reg.sv
// rtl/mem_wb_skid_reg.sv - MEM->WB pipeline register with two-entry skid buffering
//
// Optional feature: define MEM_WB_STALL_CNT_EN to add the stall_cnt port.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous discard of all held entries
//   in_valid/in_ready upstream handshake; in_ready is registered (= skid empty)
//   in_*              incoming control bits and payload
//   out_valid/out_ready downstream handshake; out_valid = main slot valid
//   out_*             main slot fields; out_wb_value selects mem_data or alu_result
//   stall_cnt         saturating count of in_valid && !in_ready cycles (optional)
module mem_wb_skid_reg
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DST_W  = DST_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wb_en,
    input  logic              in_mem_rd_en,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [DST_W-1:0]  in_dst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wb_en,
    output logic              out_mem_rd_en,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_mem_data,
    output logic [DST_W-1:0]  out_dst,
    output logic [DATA_W-1:0] out_wb_value
`ifdef MEM_WB_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int ENTRY_W = entry_w(DATA_W, DST_W);

    // Same field order as mem_wb_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic              wb_en;
        logic              mem_rd_en;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] mem_data;
        logic [DST_W-1:0]  dst;
    } entry_t;

    mem_wb_state_t r_state;
    logic          r_out_valid;
    logic          r_in_ready;

    entry_t w_in;
    entry_t w_main;
    entry_t w_skid;
    entry_t w_main_d;
    logic   w_accept;
    logic   w_fire;
    logic   w_main_load;
    logic   w_skid_load;

    assign w_in     = '{wb_en: in_wb_en, mem_rd_en: in_mem_rd_en, alu_result: in_alu_result,
                        mem_data: in_mem_data, dst: in_dst};
    assign w_accept = in_valid & r_in_ready;
    assign w_fire   = r_out_valid & out_ready;

    // Slot load steering. During a flush nothing loads, so a same-cycle input is dropped.
    always_comb begin
        w_main_load = 1'b0;
        w_skid_load = 1'b0;
        w_main_d    = w_in;
        if (!flush) begin
            case (r_state)
                EMPTY: w_main_load = w_accept;
                ONE: begin
                    w_main_load = w_fire & w_accept;
                    w_skid_load = w_accept & ~w_fire;
                end
                TWO: begin
                    // Skid promotes into main; the skid itself is never presented.
                    w_main_load = w_fire;
                    w_main_d    = w_skid;
                end
                default: ;
            endcase
        end
    end

    mem_wb_entry #(.W(ENTRY_W)) u_main (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_main_load),
        .i_clr_ctrl (flush),
        .i_d        (w_main_d),
        .o_q        (w_main)
    );

    mem_wb_entry #(.W(ENTRY_W)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_skid_load),
        .i_clr_ctrl (flush),
        .i_d        (w_in),
        .o_q        (w_skid)
    );

    // Handshake outputs are registered with the state so in_ready has no
    // combinational path from out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (flush) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_state     <= ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (w_fire && !w_accept) begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                    end else if (w_accept && !w_fire) begin
                        r_state    <= TWO;
                        r_in_ready <= 1'b0;
                    end
                end
                TWO: begin
                    if (w_fire) begin
                        r_state    <= ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef MEM_WB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Flush does not clear the counter; only reset does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (in_valid && !r_in_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign in_ready       = r_in_ready;
    assign out_valid      = r_out_valid;
    assign out_wb_en      = w_main.wb_en;
    assign out_mem_rd_en  = w_main.mem_rd_en;
    assign out_alu_result = w_main.alu_result;
    assign out_mem_data   = w_main.mem_data;
    assign out_dst        = w_main.dst;
    assign out_wb_value   = w_main.mem_rd_en ? w_main.mem_data : w_main.alu_result;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// tb/tb_mem_wb_skid_reg.sv - self-checking bench for mem_wb_skid_reg
module tb_mem_wb_skid_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_wb_en;
    logic        in_mem_rd_en;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_data;
    logic [3:0]  in_dst;
    logic        out_valid;
    logic        out_ready;
    logic        out_wb_en;
    logic        out_mem_rd_en;
    logic [31:0] out_alu_result;
    logic [31:0] out_mem_data;
    logic [3:0]  out_dst;
    logic [31:0] out_wb_value;
`ifdef MEM_WB_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    mem_wb_skid_reg #(.DATA_W(32), .DST_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_wb_en       (in_wb_en),
        .in_mem_rd_en   (in_mem_rd_en),
        .in_alu_result  (in_alu_result),
        .in_mem_data    (in_mem_data),
        .in_dst         (in_dst),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_wb_en      (out_wb_en),
        .out_mem_rd_en  (out_mem_rd_en),
        .out_alu_result (out_alu_result),
        .out_mem_data   (out_mem_data),
        .out_dst        (out_dst),
        .out_wb_value   (out_wb_value)
`ifdef MEM_WB_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wb_en;
        logic        rd_en;
        logic [31:0] alu;
        logic [31:0] mdata;
        logic [3:0]  dst;
    } ent_t;

    // Reference: a FIFO of at most two instructions.
    ent_t model_q[$];
    bit   ctrl_zero;
    int   exp_stall;
    int   errors = 0;
    int   checks = 0;

    task automatic drive(input logic v, input logic wb, input logic rd,
                         input logic [31:0] alu, input logic [31:0] md, input logic [3:0] dst);
        in_valid      = v;
        in_wb_en      = wb;
        in_mem_rd_en  = rd;
        in_alu_result = alu;
        in_mem_data   = md;
        in_dst        = dst;
    endtask

    // Advance one clock and apply the handshake rules to the model.
    task automatic tick();
        bit   fire;
        bit   acc;
        ent_t e;
        fire = (model_q.size() > 0) && out_ready;
        acc  = in_valid && (model_q.size() < 2);
        e = '{wb_en: in_wb_en, rd_en: in_mem_rd_en, alu: in_alu_result,
              mdata: in_mem_data, dst: in_dst};
        if (in_valid && model_q.size() == 2 && exp_stall < 65535) exp_stall++;
        @(posedge clk);
        if (flush) begin
            model_q.delete();
            ctrl_zero = 1'b1;
        end else begin
            if (fire) void'(model_q.pop_front());
            if (acc) begin
                model_q.push_back(e);
                ctrl_zero = 1'b0;
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        model_q.delete();
        ctrl_zero = 1'b1;
        exp_stall = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        checks++;
        if ({out_wb_en, out_mem_rd_en, out_alu_result, out_mem_data, out_dst, out_wb_value} !== '0) begin
            errors++;
            $display("FAIL reset_payload got wb=%b rd=%b alu=%h md=%h dst=%h wbv=%h want all 0",
                     out_wb_en, out_mem_rd_en, out_alu_result, out_mem_data, out_dst, out_wb_value);
        end
`ifdef MEM_WB_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_stall got %0d want 0", stall_cnt);
        end
`endif
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h1234, 32'h0, 4'h3);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++;
        if (out_valid !== 1'b1 || out_wb_value !== 32'h1234 || out_dst !== 4'h3) begin
            errors++;
            $display("FAIL single_out got v=%b wbv=%h dst=%h want 1 00001234 3", out_valid, out_wb_value, out_dst);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int ready_low = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (in_ready !== 1'b1) ready_low++;
            drive(1'b1, 1'b1, 1'b0, 32'h100 + i * 32'h11, 32'h0, 4'(i));
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_alu_result !== 32'h100 + i * 32'h11 || out_dst !== 4'(i)) begin
                errors++;
                $display("FAIL b2b_out[%0d] got v=%b alu=%h dst=%h want 1 %h %h",
                         i, out_valid, out_alu_result, out_dst, 32'h100 + i * 32'h11, 4'(i));
            end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        if (in_ready !== 1'b1) ready_low++;
        checks++;
        if (ready_low != 0) begin
            errors++;
            $display("FAIL b2b_in_ready got %0d low cycles want 0", ready_low);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'hA001, 32'h0, 4'h1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'hA002, 32'h0, 4'h2);
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_alu_result !== 32'hA001) begin
            errors++;
            $display("FAIL bp_two got rdy=%b v=%b alu=%h want 0 1 0000a001", in_ready, out_valid, out_alu_result);
        end
        drive(1'b1, 1'b1, 1'b0, 32'hA003, 32'h0, 4'h3);
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_alu_result !== 32'hA001) begin
            errors++;
            $display("FAIL bp_hold got rdy=%b alu=%h want 0 0000a001", in_ready, out_alu_result);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_alu_result !== 32'hA002) begin
            errors++;
            $display("FAIL bp_rel1 got rdy=%b v=%b alu=%h want 1 1 0000a002", in_ready, out_valid, out_alu_result);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++;
        if (out_valid !== 1'b1 || out_alu_result !== 32'hA003 || out_dst !== 4'h3) begin
            errors++;
            $display("FAIL bp_rel2 got v=%b alu=%h dst=%h want 1 0000a003 3", out_valid, out_alu_result, out_dst);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_mem_read();
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 32'h0010, 32'hDEAD, 4'h5);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++;
        if (out_valid !== 1'b1 || out_wb_value !== 32'hDEAD) begin
            errors++;
            $display("FAIL mem_read got v=%b wbv=%h want 1 0000dead", out_valid, out_wb_value);
        end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 32'hB001, 32'hC001, 4'h6);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'hB002, 32'hC002, 4'h7);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'hB003, 32'hC003, 4'h8);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_wb_en !== 1'b0 || out_mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL flush_two got v=%b rdy=%b wb=%b rd=%b want 0 1 0 0",
                     out_valid, in_ready, out_wb_en, out_mem_rd_en);
        end
        checks++;
        if (out_alu_result !== 32'hB001 || out_mem_data !== 32'hC001 || out_dst !== 4'h6) begin
            errors++;
            $display("FAIL flush_payload got alu=%h md=%h dst=%h want 0000b001 0000c001 6",
                     out_alu_result, out_mem_data, out_dst);
        end
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'hB004, 32'h0, 4'h9);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'hB005, 32'h0, 4'hA);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_wb_en !== 1'b0 || out_alu_result === 32'hB005) begin
            errors++;
            $display("FAIL flush_one_drop got v=%b wb=%b alu=%h want 0 0 not 0000b005",
                     out_valid, out_wb_en, out_alu_result);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            drive($urandom_range(0, 2) != 0, 1'($urandom), 1'($urandom),
                  $urandom, $urandom, 4'($urandom));
            tick();
            checks++;
            if (out_valid !== (model_q.size() > 0) || in_ready !== (model_q.size() < 2)) begin
                errors++;
                $display("FAIL rand_status[%0d] got v=%b rdy=%b want v=%b rdy=%b",
                         c, out_valid, in_ready, model_q.size() > 0, model_q.size() < 2);
            end
            if (model_q.size() > 0) begin
                checks++;
                if (out_wb_en !== model_q[0].wb_en || out_mem_rd_en !== model_q[0].rd_en ||
                    out_alu_result !== model_q[0].alu || out_mem_data !== model_q[0].mdata ||
                    out_dst !== model_q[0].dst ||
                    out_wb_value !== (model_q[0].rd_en ? model_q[0].mdata : model_q[0].alu)) begin
                    errors++;
                    $display("FAIL rand_payload[%0d] got wb=%b rd=%b alu=%h md=%h dst=%h wbv=%h want %b %b %h %h %h",
                             c, out_wb_en, out_mem_rd_en, out_alu_result, out_mem_data, out_dst, out_wb_value,
                             model_q[0].wb_en, model_q[0].rd_en, model_q[0].alu, model_q[0].mdata, model_q[0].dst);
                end
            end else if (ctrl_zero) begin
                checks++;
                if (out_wb_en !== 1'b0 || out_mem_rd_en !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_ctrl_clr[%0d] got wb=%b rd=%b want 0 0", c, out_wb_en, out_mem_rd_en);
                end
            end
`ifdef MEM_WB_STALL_CNT_EN
            checks++;
            if (stall_cnt !== 16'(exp_stall)) begin
                errors++;
                $display("FAIL rand_stall[%0d] got %0d want %0d", c, stall_cnt, exp_stall);
            end
`endif
        end
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

`ifdef MEM_WB_STALL_CNT_EN
    task automatic test_stall_cnt();
        apply_reset();
        drive(1'b1, 1'b1, 1'b0, 32'hD001, 32'h0, 4'h1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'hD002, 32'h0, 4'h2);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'hD003, 32'h0, 4'h3);
        repeat (5) tick();
        checks++;
        if (stall_cnt !== 16'd5) begin
            errors++;
            $display("FAIL stall_five got %0d want 5", stall_cnt);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (stall_cnt !== 16'd5) begin
            errors++;
            $display("FAIL stall_flush got %0d want 5", stall_cnt);
        end
        apply_reset();
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stall_reset got %0d want 0", stall_cnt);
        end
    endtask
`endif

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 32'hE001, 32'hF001, 4'hC);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'hE002, 32'hF002, 4'hD);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_alu_result !== 32'h0 || out_wb_value !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got v=%b rdy=%b alu=%h wbv=%h want 0 1 0 0",
                     out_valid, in_ready, out_alu_result, out_wb_value);
        end
        apply_reset();
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_lost got out_valid=%b want 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_mem_read();
        test_flush();
        test_random();
`ifdef MEM_WB_STALL_CNT_EN
        test_stall_cnt();
`endif
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
